// File: rtl/triangular_unwind.sv
// Inverse of the triangular accumulator: peels off terms 0,1,2,... from a sum
// and reports the term count, the remainder and whether the loop bound was hit.
module triangular_unwind #(
    parameter int WIDTH = 13,
    parameter int LIMIT = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_count,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_exact,
    output logic             out_ovf
);

    localparam logic [WIDTH-1:0] I_MAX = WIDTH'(LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] r, r_next;
    logic [WIDTH-1:0] i, i_next;
    logic             ovf, ovf_next;
    logic             exact, exact_next;

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_next = state;
        r_next     = r;
        i_next     = i;
        ovf_next   = ovf;
        exact_next = exact;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    r_next     = in_sum;
                    i_next     = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                // The bound check wins over a further subtraction.
                if (i == I_MAX) begin
                    ovf_next   = (r >= i);
                    exact_next = (r == '0);
                    state_next = DONE;
                end else if (r >= i) begin
                    r_next = r - i;
                    i_next = i + 1'b1;
                end else begin
                    ovf_next   = 1'b0;
                    exact_next = (r == '0);
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state <= IDLE;
            r     <= '0;
            i     <= '0;
            ovf   <= 1'b0;
            exact <= 1'b0;
        end else begin
            state <= state_next;
            r     <= r_next;
            i     <= i_next;
            ovf   <= ovf_next;
            exact <= exact_next;
        end
    end

    // exact is registered at the RUN->DONE transition so it stays 0 out of reset.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_count = i;
    assign out_rem   = r;
    assign out_exact = exact;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_triangular_unwind.sv
// Self-checking bench for triangular_unwind: directed cases, backpressure,
// reset abort and randomized sums against a loop-level reference model.
module tb_triangular_unwind;

    localparam int WIDTH = 13;
    localparam int LIMIT = 100;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_count;
    logic [WIDTH-1:0] out_rem;
    logic             out_exact;
    logic             out_ovf;

    int n_vec = 0;
    int n_bad = 0;

    triangular_unwind #(.WIDTH(WIDTH), .LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_rem   (out_rem),
        .out_exact (out_exact),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: remove 0,1,2,...,LIMIT while possible.
    task automatic model(input int sum, output int count, output int rem, output bit ovf);
        int s = sum;
        int k = 0;
        for (int t = 0; t <= LIMIT; t++) begin
            if (s >= t) begin
                s -= t;
                k++;
            end else begin
                break;
            end
        end
        count = k;
        rem   = s;
        ovf   = (k == LIMIT + 1) && (s >= k);
    endtask

    // Submit one sum, wait for the result and check everything; leaves it in DONE.
    task automatic run_txn(input string tag, input int sum);
        int  e_count, e_rem, cycles;
        bit  e_ovf;
        model(sum, e_count, e_rem, e_ovf);
        check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sum   = WIDTH'(sum);
        step();
        in_valid = 1'b0;
        cycles   = 0;
        while (!out_valid && cycles < 300) begin
            step();
            cycles++;
        end
        check({tag, ":latency"}, 32'(cycles), 32'(e_count + 1));
        check({tag, ":count"}, 32'(out_count), 32'(e_count));
        check({tag, ":rem"}, 32'(out_rem), 32'(e_rem));
        check({tag, ":ovf"}, 32'(out_ovf), 32'(e_ovf));
        check({tag, ":exact"}, 32'(out_exact), 32'((e_rem == 0) && !e_ovf));
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ":drop_valid"}, 32'(out_valid), 32'd0);
        check({tag, ":ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] held_count, held_rem;
        logic             held_exact, held_ovf;
        int               gap;

        // Reset with in_valid asserted: nothing is captured.
        rst      = 1'b0;
        in_valid = 1'b1;
        in_sum   = 13'd5;
        step();
        step();
        check("rst:in_ready", 32'(in_ready), 32'd1);
        check("rst:out_valid", 32'(out_valid), 32'd0);
        check("rst:count", 32'(out_count), 32'd0);
        check("rst:rem", 32'(out_rem), 32'd0);
        check("rst:exact", 32'(out_exact), 32'd0);
        check("rst:ovf", 32'(out_ovf), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        check("rst:idle_after", 32'(in_ready), 32'd1);

        // Directed cases, including the loop-bound boundaries.
        run_txn("s5050", 5050); drain("s5050");
        run_txn("s0", 0);       drain("s0");
        run_txn("s5151", 5151); drain("s5151");
        run_txn("s8191", 8191); drain("s8191");
        run_txn("s5149", 5149); drain("s5149");

        // Backpressure: result held, new in_valid ignored.
        run_txn("s7", 7);
        held_count = out_count;
        held_rem   = out_rem;
        held_exact = out_exact;
        held_ovf   = out_ovf;
        in_valid   = 1'b1;
        in_sum     = 13'd100;
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp:valid", 32'(out_valid), 32'd1);
            check("bp:in_ready", 32'(in_ready), 32'd0);
            check("bp:count", 32'(out_count), 32'(held_count));
            check("bp:rem", 32'(out_rem), 32'(held_rem));
            check("bp:exact", 32'(out_exact), 32'(held_exact));
            check("bp:ovf", 32'(out_ovf), 32'(held_ovf));
        end
        in_valid = 1'b0;
        drain("bp");
        run_txn("s10", 10); drain("s10");

        // Reset in the middle of a long RUN aborts the result.
        in_valid = 1'b1;
        in_sum   = 13'd5050;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 39; c++) step();
        check("abort:running", 32'(out_valid), 32'd0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("abort:in_ready", 32'(in_ready), 32'd1);
        check("abort:out_valid", 32'(out_valid), 32'd0);
        check("abort:count", 32'(out_count), 32'd0);
        step();
        check("abort:no_result", 32'(out_valid), 32'd0);
        run_txn("s3", 3); drain("s3");

        // Randomized sums with random consumer stall.
        for (int n = 0; n < 25; n++) begin
            run_txn($sformatf("rnd%0d", n), int'($urandom_range(0, 8191)));
            gap = int'($urandom_range(0, 4));
            for (int g = 0; g < gap; g++) step();
            check("rnd:held", 32'(out_valid), 32'd1);
            drain("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
